// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state codes and constants for the instruction-memory responder
package imem_pkg;

    localparam int          CNT_W    = 4;
    localparam logic [15:0] NOP_INSN = 16'h0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_PREF = 2'd3;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 16-bit instruction storage, synchronous write, combinational read, no reset
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [15:0]           wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [15:0]           rd_data
);

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with stall/done handshake
// Optional next-line prefetch buffer enabled by IMEM_PREFETCH_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              stall,
    output logic              done,
    output logic [15:0]       data_out,
    output logic              err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data
);

    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [15:0]           rd_data;
    logic                  can_accept;
    logic                  unused_addr_bits;

    // Only the word index matters; upper bits alias and wr_addr[0] is ignored.
    assign req_idx = req_addr[DEPTH_LOG2:1];
    assign wr_idx  = wr_addr[DEPTH_LOG2:1];
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], wr_addr[ADDR_W-1:DEPTH_LOG2+1], wr_addr[0]};

    assign can_accept = (state == ST_IDLE) || (state == ST_PREF);
    assign stall      = (state == ST_BUSY);
    assign done       = (state == ST_DONE);

`ifdef IMEM_PREFETCH_EN
    localparam logic [CNT_W-1:0] LAT_FULL = CNT_W'(LATENCY);

    logic                  buf_valid;
    logic [DEPTH_LOG2-1:0] buf_tag;
    logic [15:0]           buf_data;
    logic [DEPTH_LOG2-1:0] pf_idx;
    logic                  hit;
    logic                  pf_kill;
    logic                  pf_fill;

    assign hit     = (state == ST_IDLE) && buf_valid && (buf_tag == req_idx);
    assign pf_kill = (state == ST_PREF) && wr_en && (wr_idx == pf_idx);
    assign pf_fill = (state == ST_PREF) && !req_valid && !pf_kill && (count == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= NOP_INSN;
        end else if (pf_fill) begin
            buf_valid <= 1'b1;
            buf_tag   <= pf_idx;
            buf_data  <= rd_data;
        end else if (pf_kill || (wr_en && (wr_idx == buf_tag))) begin
            buf_valid <= 1'b0;
        end
    end
`endif

    always_comb begin
        rd_idx = lat_idx;
        if (can_accept && req_valid) begin
            rd_idx = req_idx;
`ifdef IMEM_PREFETCH_EN
        end else if (state == ST_PREF) begin
            rd_idx = pf_idx;
`endif
        end
    end

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            lat_idx  <= '0;
            data_out <= NOP_INSN;
            err      <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            pf_idx   <= '0;
`endif
        end else if (can_accept && req_valid) begin
            lat_idx <= req_idx;
            count   <= LAT_M1;
            if (req_addr[0]) begin
                state    <= ST_DONE;
                err      <= 1'b1;
                data_out <= NOP_INSN;
`ifdef IMEM_PREFETCH_EN
            end else if (hit) begin
                state    <= ST_DONE;
                err      <= 1'b0;
                data_out <= buf_data;
`endif
            end else if (LATENCY == 1) begin
                state    <= ST_DONE;
                err      <= 1'b0;
                data_out <= rd_data;
            end else begin
                state <= ST_BUSY;
            end
        end else begin
            case (state)
                ST_BUSY: begin
                    count <= count - CNT_ONE;
                    // Sampling here lets a write on an earlier edge win, but not one on this edge.
                    if (count == CNT_ONE) begin
                        state    <= ST_DONE;
                        data_out <= rd_data;
                        err      <= 1'b0;
                    end
                end
                ST_DONE: begin
`ifdef IMEM_PREFETCH_EN
                    if (!err) begin
                        state  <= ST_PREF;
                        pf_idx <= lat_idx + 1'b1;
                        count  <= LAT_FULL;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_PREF: begin
`ifdef IMEM_PREFETCH_EN
                    count <= count - CNT_ONE;
                    if (pf_kill || (count == CNT_ONE)) begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench with a shadow-memory response model
module tb_imem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = 16'h0;
    logic [15:0] wr_data = 16'h0;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;
    bit model_en = 1'b0;

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W     (16),
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .stall     (stall),
        .done      (done),
        .data_out  (data_out),
        .err       (err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: one outstanding request, done LAT edges after acceptance, data seen by the
    // memory just before the edge that completes it.
    logic [15:0] shadow [0:1023];
    int          ecnt = 0;
    int          m_fin = 0;
    bit          m_busy = 1'b0;
    bit          m_mis = 1'b0;
    logic [9:0]  m_idx = '0;
    logic        m_stall = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_data = 16'h0;

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 16'h0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_stall = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_data  = 16'h0;
        end else begin
            ecnt++;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1;
                    m_mis  = req_addr[0];
                    m_idx  = req_addr[10:1];
                    m_fin  = m_mis ? ecnt : ecnt + LAT - 1;
                end
            end else if (ecnt == m_fin + 1) begin
                m_busy = 1'b0;
            end
            m_stall = m_busy && (ecnt < m_fin);
            m_done  = m_busy && (ecnt == m_fin);
            if (m_done) begin
                m_err  = m_mis;
                m_data = m_mis ? 16'h0 : shadow[m_idx];
            end
            if (wr_en) shadow[wr_addr[10:1]] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (model_en && !rst) begin
            check("stall", 32'(stall), 32'(m_stall));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("data_out", 32'(data_out), 32'(m_data));
        end
    end

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_req(input logic [15:0] a);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic write_at(input int k, input logic [15:0] a, input logic [15:0] d);
        repeat (k - 1) @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(output int stalls, output int cyc);
        stalls = 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            if (stall) stalls++;
            cyc++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    int s, c, dcount;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", 32'(data_out), 32'h0);
        rst = 1'b0;
        model_en = 1'b1;

        load(16'h0004, 16'hA5A5);
        start_req(16'h0004);
        wait_done(s, c);
        check("t1_stalls", 32'(s), 32'd3);
        check("t1_latency", 32'(c), 32'd3);
        check("t1_data", 32'(data_out), 32'hA5A5);
        check("t1_err", 32'(err), 32'd0);

        start_req(16'h0003);
        wait_done(s, c);
        check("t2_stalls", 32'(s), 32'd0);
        check("t2_latency", 32'(c), 32'd0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_data", 32'(data_out), 32'h0);
        @(negedge clk);
        check("t2_done_pulse", 32'(done), 32'd0);

        load(16'h0010, 16'h5555);
        start_req(16'h0010);
        write_at(2, 16'h0010, 16'h1234);
        wait_done(s, c);
        check("t3_new_data", 32'(data_out), 32'h1234);

        load(16'h0010, 16'h5555);
        start_req(16'h0010);
        write_at(3, 16'h0010, 16'hCAFE);
        wait_done(s, c);
        check("t3_old_data", 32'(data_out), 32'h5555);

        start_req(16'h0010);
        check("t4_busy", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_stall", 32'(stall), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_data", 32'(data_out), 32'h0);
        check("t4_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t4_no_done", 32'(dcount), 32'd0);
        start_req(16'h0010);
        wait_done(s, c);
        check("t4_retry_data", 32'(data_out), 32'hCAFE);
        check("t4_retry_stalls", 32'(s), 32'd3);

        load(16'h0002, 16'hBEEF);
        start_req(16'h0802);
        wait_done(s, c);
        check("t5_wrap_data", 32'(data_out), 32'hBEEF);

        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'h0004;
        repeat (12) @(negedge clk);
        req_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("t6_burst_data", 32'(data_out), 32'hA5A5);

`ifdef IMEM_PREFETCH_EN
        model_en = 1'b0;
        load(16'h0020, 16'h1111);
        load(16'h0022, 16'h2222);
        start_req(16'h0020);
        wait_done(s, c);
        repeat (LAT + 1) @(negedge clk);
        start_req(16'h0022);
        check("pf_hit_done", 32'(done), 32'd1);
        check("pf_hit_stall", 32'(stall), 32'd0);
        check("pf_hit_data", 32'(data_out), 32'h2222);
        write_at(2, 16'h0024, 16'h3333);
        repeat (LAT + 1) @(negedge clk);
        start_req(16'h0024);
        wait_done(s, c);
        check("pf_miss_stalls", 32'(s), 32'd3);
        check("pf_miss_data", 32'(data_out), 32'h3333);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
